// File: rtl/ddr2_port_responder.sv
// ddr2_port_responder: DDR2 user-port stand-in backed by an on-chip word buffer
// with wrapping read/write address windows and a fixed power-up delay.
module ddr2_port_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 24,
    parameter int MEM_AW      = 10,
    parameter int INIT_CYCLES = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] wr_minaddr,
    input  logic [ADDR_W-1:0] wr_maxaddr,
    input  logic              wr_load,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_minaddr,
    input  logic [ADDR_W-1:0] rd_maxaddr,
    input  logic              rd_load,
    output logic              local_init_done,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              req_err
);
    localparam int CW = $clog2(INIT_CYCLES + 1);
    typedef enum logic {INIT, READY} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] mem [2**MEM_AW];
    logic wr_go, rd_go;
    // Degenerate windows (max <= min) pin the pointer to min.
    function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] p, mn, mx);
        logic [ADDR_W-1:0] n;
        n = p + 1'b1;
        return (n >= mx || mx <= mn) ? mn : n;
    endfunction
    always_comb begin
        state_nxt = state;
        if (state == INIT && cnt == CW'(INIT_CYCLES - 1)) state_nxt = READY;
    end
    assign local_init_done = state == READY;
    assign wr_go = local_init_done && wr_req && !wr_load;
    assign rd_go = local_init_done && rd_req && !rd_load;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            cnt      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            req_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            if (state == INIT) cnt <= cnt + 1'b1;
            rd_valid <= rd_go;
            if (rd_go) rd_data <= mem[rd_addr[MEM_AW-1:0]];
            wr_addr  <= wr_load ? wr_minaddr : wr_go ? step(wr_addr, wr_minaddr, wr_maxaddr) : wr_addr;
            rd_addr  <= rd_load ? rd_minaddr : rd_go ? step(rd_addr, rd_minaddr, rd_maxaddr) : rd_addr;
            if ((wr_req || rd_req) && !local_init_done) req_err <= 1'b1;
        end
    end
    // Buffer is intentionally not reset; the read above sees the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_go) mem[wr_addr[MEM_AW-1:0]] <= wr_data;
    end
endmodule

// File: tb/tb_ddr2_port_responder.sv
// tb_ddr2_port_responder: directed stimulus; expected read words are queued at
// issue and a negedge monitor pops and compares whenever rd_valid is high.
module tb_ddr2_port_responder;
    logic        clk = 0, rst = 1;
    logic        wr_req = 0, wr_load = 0, rd_req = 0, rd_load = 0;
    logic [31:0] wr_data = 0, rd_data;
    logic [23:0] wr_minaddr = 0, wr_maxaddr = 0, rd_minaddr = 0, rd_maxaddr = 0;
    logic [23:0] wr_addr, rd_addr;
    logic        rd_valid, local_init_done, req_err;
    int checks = 0, failures = 0;
    logic [31:0] exp_q[$];

    ddr2_port_responder dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data),
        .wr_minaddr(wr_minaddr), .wr_maxaddr(wr_maxaddr), .wr_load(wr_load),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_minaddr(rd_minaddr), .rd_maxaddr(rd_maxaddr), .rd_load(rd_load),
        .local_init_done(local_init_done), .wr_addr(wr_addr), .rd_addr(rd_addr),
        .req_err(req_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected actual=%h required=no_valid", rd_data);
            end else chk("rd_data", rd_data, exp_q.pop_front());
        end
    end

    initial begin
        logic [23:0] seq4 [6];
        seq4 = '{24'd4, 24'd5, 24'd6, 24'd7, 24'd4, 24'd5};
        repeat (3) tick();
        chk("rst_init_done", 32'(local_init_done), 0);
        chk("rst_req_err", 32'(req_err), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        @(negedge clk) rst = 0;
        for (int c = 1; c <= 200; c++) begin
            wr_req = (c == 10);
            wr_data = 32'hBAD0_0000;
            tick();
            wr_req = 0;
            if (c >= 198) chk("init_done_timing", 32'(local_init_done), 32'(c == 200));
            if (c == 9) chk("req_err_before", 32'(req_err), 0);
            if (c == 10) begin
                chk("req_err_init_wr", 32'(req_err), 1);
                chk("wr_addr_init_wr", 32'(wr_addr), 0);
            end
        end
        chk("req_err_sticky_ready", 32'(req_err), 1);
        // full window burst write then read
        wr_minaddr = 0; wr_maxaddr = 1024; rd_minaddr = 0; rd_maxaddr = 1024;
        wr_load = 1; rd_load = 1; tick(); wr_load = 0; rd_load = 0;
        wr_req = 1;
        for (int i = 0; i < 64; i++) begin
            wr_data = 32'hA500_0000 + i;
            tick();
        end
        wr_req = 0;
        chk("wr_addr_after64", 32'(wr_addr), 64);
        rd_req = 1;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(32'hA500_0000 + i);
            tick();
            if (i == 0) chk("rd_latency1", 32'(rd_valid), 1);
        end
        rd_req = 0;
        tick();
        chk("rd_valid_idle", 32'(rd_valid), 0);
        chk("rd_data_hold", rd_data, 32'hA500_003F);
        // window 4..8 wraps
        wr_minaddr = 4; wr_maxaddr = 8;
        wr_load = 1; tick(); wr_load = 0;
        for (int i = 0; i < 6; i++) begin
            chk("wr_addr_wrap_seq", 32'(wr_addr), 32'(seq4[i]));
            wr_req = 1; wr_data = i + 1;
            tick();
        end
        wr_req = 0;
        chk("wr_addr_wrap_end", 32'(wr_addr), 6);
        rd_minaddr = 4; rd_maxaddr = 8;
        rd_load = 1; tick(); rd_load = 0;
        rd_req = 1;
        foreach (seq4[i]) if (i < 5) begin
            exp_q.push_back((i == 0) ? 5 : (i == 1) ? 6 : (i == 2) ? 3 : (i == 3) ? 4 : 5);
            tick();
        end
        rd_req = 0;
        chk("rd_addr_wrap_end", 32'(rd_addr), 5);
        // read-before-write at index 3
        wr_minaddr = 3; wr_maxaddr = 1024; rd_minaddr = 3; rd_maxaddr = 1024;
        wr_load = 1; rd_load = 1; tick(); rd_load = 0; wr_load = 0;
        wr_req = 1; wr_data = 32'h11; tick(); wr_req = 0;
        wr_load = 1; tick(); wr_load = 0;
        wr_req = 1; wr_data = 32'h22; rd_req = 1; exp_q.push_back(32'h11);
        tick();
        wr_req = 0; rd_req = 0;
        chk("rbw_valid", 32'(rd_valid), 1);
        rd_load = 1; tick(); rd_load = 0;
        rd_req = 1; exp_q.push_back(32'h22); tick(); rd_req = 0;
        // load beats a simultaneous write at wr_addr 7
        wr_minaddr = 4; wr_maxaddr = 8;
        wr_load = 1; tick(); wr_load = 0;
        wr_req = 1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 32'h40 + i;
            tick();
        end
        chk("wr_addr_at7", 32'(wr_addr), 7);
        wr_load = 1; wr_data = 32'hDEAD; tick(); wr_load = 0; wr_req = 0;
        chk("wr_load_wins", 32'(wr_addr), 4);
        rd_minaddr = 7; rd_maxaddr = 8;
        rd_load = 1; tick();
        rd_req = 1; tick();
        chk("rd_load_drops_read", 32'(rd_valid), 0);
        rd_load = 0;
        exp_q.push_back(32'd4); tick(); rd_req = 0;
        // degenerate window holds the pointer
        rd_minaddr = 9; rd_maxaddr = 9;
        rd_load = 1; tick(); rd_load = 0;
        rd_req = 1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(32'hA500_0009);
            tick();
            chk("rd_addr_degenerate", 32'(rd_addr), 9);
        end
        rd_req = 0;
        tick();
        chk("rd_outstanding", 32'(exp_q.size()), 0);
        // asynchronous reset mid-burst
        wr_minaddr = 0; wr_maxaddr = 1024;
        wr_load = 1; tick(); wr_load = 0;
        wr_req = 1; wr_data = 32'h5;
        tick(); tick();
        #2 rst = 1;
        #1;
        chk("arst_wr_addr", 32'(wr_addr), 0);
        chk("arst_init_done", 32'(local_init_done), 0);
        chk("arst_req_err", 32'(req_err), 0);
        chk("arst_rd_data", rd_data, 0);
        wr_req = 0;
        @(negedge clk) rst = 0;
        repeat (5) tick();
        chk("rerun_init_done", 32'(local_init_done), 0);
        chk("rerun_req_err", 32'(req_err), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
